// File: rtl/reception8_pkg.sv
// Shared constants and FSM state encoding for the select-routed link receiver.
package reception8_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/reception8_check.sv
// Combinational idle-line checker: flags any low line other than the selected one.
module reception8_check
  import reception8_pkg::*;
(
  input  logic [WIDTH-1:0] lines,
  input  logic [SEL_W-1:0] cnt,
  output logic             viol
);

  logic [WIDTH-1:0] sel_mask;

  always_comb begin
    sel_mask      = '0;
    sel_mask[cnt] = 1'b1;
    viol          = |(~lines & ~sel_mask);
  end

endmodule

// File: rtl/reception8.sv
// Scans select code 0..7, captures one line per cycle, strobes the word 9 cycles after start.
// Optional idle-line check is built only with RECEPTION8_CHECK_EN defined.
module reception8
  import reception8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] iLines,
  input  logic             iStart,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  output logic             oBusy,
  output logic             oError
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  state_t           state;
  logic [SEL_W-1:0] cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] word;

  // Final bit comes straight from the line so oData is complete on the DONE edge.
  always_comb begin
    word      = shift;
    word[cnt] = iLines[cnt];
  end

  assign {A, B, C} = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      shift  <= '0;
      oData  <= '0;
      oValid <= 1'b0;
      oBusy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (iStart) begin
            state <= SCAN;
            oBusy <= 1'b1;
          end
        end
        SCAN: begin
          shift[cnt] <= iLines[cnt];
          if (cnt == LAST) begin
            state  <= DONE;
            cnt    <= '0;
            oData  <= word;
            oValid <= 1'b1;
            oBusy  <= 1'b0;
          end else begin
            cnt <= cnt + SEL_W'(1);
          end
        end
        DONE: begin
          oValid <= 1'b0;
          if (iStart) begin
            state <= SCAN;
            oBusy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          oValid <= 1'b0;
          oBusy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RECEPTION8_CHECK_EN
  logic viol;
  logic err;

  reception8_check u_check (
    .lines (iLines),
    .cnt   (cnt),
    .viol  (viol)
  );

  // Sticky per-word flag; cleared whenever a new scan is about to begin.
  always_ff @(posedge clk) begin
    if (rst) begin
      err    <= 1'b0;
      oError <= 1'b0;
    end else begin
      oError <= 1'b0;
      if (state == SCAN) begin
        err <= err | viol;
        if (cnt == LAST) oError <= err | viol;
      end else if (iStart) begin
        err <= 1'b0;
      end
    end
  end
`else
  assign oError = 1'b0;
`endif

endmodule

// File: doc/reception8.md
# reception8

Receiving end of the 8-line select-routed link. The transmit side places one data bit on the line chosen by the select code {A,B,C} and holds every other line high. This block drives that select code itself and scans it from 0 to 7, capturing one bit per cycle. It then reassembles the 8-bit word and presents it with a one-cycle valid strobe. It sits directly opposite the transmitter: its A/B/C outputs drive the transmitter's select inputs, and its iLines inputs take the transmitter's eight output lines.

## Interface
Parameters:
- WIDTH, 8, number of lines and word width; fixed at 8, not to be overridden.
- SEL_W, 3, select code width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- iLines  in  8  lines from the transmitter; unselected lines idle high.
- iStart  in  1  request one word capture; level-sampled, acted on only in IDLE or DONE.
- A  out  1  select MSB (cnt[2]).
- B  out  1  select bit 1 (cnt[1]).
- C  out  1  select LSB (cnt[0]).
- oData  out  8  last captured word; holds until the next DONE.
- oValid  out  1  one-cycle strobe; oData is new this cycle.
- oBusy  out  1  high while in SCAN.
- oError  out  1  idle-line violation in this word; qualified by oValid.

## Operation
- States:
  - IDLE: cnt=0, oBusy=0.
  - SCAN: cnt counts 0..7.
  - DONE: one cycle, oValid=1.
- Transitions:
  - IDLE→SCAN when iStart=1.
  - SCAN→DONE on the edge that captures cnt=7.
  - DONE→SCAN if iStart=1 (back-to-back capture), otherwise DONE→IDLE.
- {A,B,C} = cnt at all times. The select code is registered, never combinational from the inputs.
- In SCAN, each edge stores iLines[cnt] into shift[cnt], then cnt increments. cnt wraps 7→0 on entry to DONE.
- On the SCAN→DONE edge, oData is loaded with the assembled shift word.
- iStart is ignored while in SCAN; no queueing.
- rst has priority over everything, including mid-SCAN:
  - state=IDLE, cnt=0, A=B=C=0.
  - oData=8'h00, oValid=0, oBusy=0, oError=0.
  - The partial word is discarded.

## Timing
- iStart seen at edge E in IDLE:
  - SCAN occupies cycles E+1..E+8, with cnt=0..7.
  - oValid is high in cycle E+9.
  - Latency from start edge to valid is 9 cycles.
- Back-to-back throughput: one word per 9 cycles.
- Each iLines sample uses the select code registered in the previous cycle. The transmitter path is combinational, so the whole round trip must close in one clock period.
- oValid and oError are never high outside DONE. oError is 0 whenever oValid=0.

## Configuration
- RECEPTION8_CHECK_EN defined:
  - On every SCAN sample, all lines other than iLines[cnt] must be 1.
  - Any 0 on an unselected line sets a sticky per-word error flag.
  - The flag is cleared on entry to SCAN and presented on oError during DONE.
- RECEPTION8_CHECK_EN undefined:
  - No check logic is built; oError is tied to 0.
  - Capture behaviour is identical in both cases.

## Structure
- Package reception8_pkg holds:
  - the WIDTH and SEL_W constants;
  - the state enum (IDLE, SCAN, DONE).
- One sub-module: reception8_check, the combinational idle-line checker that takes iLines and cnt and returns a violation bit. It is instantiated only under RECEPTION8_CHECK_EN.
- The FSM, counter and assembly register stay in the top module.

## Test plan
- Reset: assert rst mid-SCAN at cnt=4 → next cycle IDLE, A=B=C=0, oData=8'h00, no oValid; a new iStart then captures normally.
- Single word: a transmitter model sends 8'hA5, iStart pulsed at edge 0 → oValid high only in cycle 9, oData=8'hA5, oError=0, {A,B,C} stepped 000..111 over cycles 1..8.
- Back-to-back:
  - iStart held high, words 8'h3C then 8'hC3.
  - oValid in cycles 9 and 18; oData=8'h3C then 8'hC3.
  - No IDLE cycle between the words.
- Ignored start: pulse iStart again at cycle 4 of SCAN → exactly one oValid at cycle 9, no extra capture.
- Check enabled: force iLines[6]=0 while cnt=2, word otherwise 8'hFF → oError=1 with oValid; the next clean word gives oError=0.
- Check disabled: the same stimulus gives oError=0, and oData reflects only the selected-line samples.
